// File: rtl/mcash_cache.sv
// Three-channel shared line cache: round-robin arbitration onto one direct-mapped tagged 128-bit line store.
// Define MCASH_FIXED_PRIO_EN for fixed priority ch0 > ch1 > ch2 instead of round-robin.
module mcash_cache #(
    parameter int IDX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         mcash_ch0_req_valid_i,
    output logic         mcash_ch0_req_allowIn_o,
    input  logic [2:0]   mcash_ch0_req_op_i,
    input  logic [27:0]  mcash_ch0_req_addr_i,
    input  logic [127:0] mcash_ch0_req_data_i,
    output logic         mcash_ch0_rtn_valid_o,
    input  logic         mcash_ch0_rtn_ready_i,
    output logic [127:0] mcash_ch0_rtn_data_o,
    input  logic         mcash_ch1_req_valid_i,
    output logic         mcash_ch1_req_allowIn_o,
    input  logic [2:0]   mcash_ch1_req_op_i,
    input  logic [27:0]  mcash_ch1_req_addr_i,
    input  logic [127:0] mcash_ch1_req_data_i,
    output logic         mcash_ch1_rtn_valid_o,
    input  logic         mcash_ch1_rtn_ready_i,
    output logic [127:0] mcash_ch1_rtn_data_o,
    input  logic         mcash_ch2_req_valid_i,
    output logic         mcash_ch2_req_allowIn_o,
    input  logic [2:0]   mcash_ch2_req_op_i,
    input  logic [27:0]  mcash_ch2_req_addr_i,
    input  logic [127:0] mcash_ch2_req_data_i,
    output logic         mcash_ch2_rtn_valid_o,
    input  logic         mcash_ch2_rtn_ready_i,
    output logic [127:0] mcash_ch2_rtn_data_o
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 28 - IDX_W;

    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_SWAP  = 3'b011;
    localparam logic [2:0] OP_INV   = 3'b100;

    logic [2:0]   req_valid;
    logic [2:0]   rtn_ready;
    logic [2:0]   req_op   [3];
    logic [27:0]  req_addr [3];
    logic [127:0] req_data [3];

    assign req_valid   = {mcash_ch2_req_valid_i, mcash_ch1_req_valid_i, mcash_ch0_req_valid_i};
    assign rtn_ready   = {mcash_ch2_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch0_rtn_ready_i};
    assign req_op[0]   = mcash_ch0_req_op_i;
    assign req_op[1]   = mcash_ch1_req_op_i;
    assign req_op[2]   = mcash_ch2_req_op_i;
    assign req_addr[0] = mcash_ch0_req_addr_i;
    assign req_addr[1] = mcash_ch1_req_addr_i;
    assign req_addr[2] = mcash_ch2_req_addr_i;
    assign req_data[0] = mcash_ch0_req_data_i;
    assign req_data[1] = mcash_ch1_req_data_i;
    assign req_data[2] = mcash_ch2_req_data_i;

    logic [2:0]   rtn_valid_q;
    logic [127:0] rtn_data_q [3];
    logic [2:0]   eligible;
    logic [2:0]   cand;
    logic [2:0]   pick;
    logic [2:0]   grant;

    // A channel may be granted only if its return slot is free or drains this cycle.
    for (genvar gi = 0; gi < 3; gi++) begin : g_elig
        assign eligible[gi] = ~rtn_valid_q[gi] | rtn_ready[gi];
    end

    assign cand  = req_valid & eligible;
    assign grant = rst_i ? pick : 3'b000;

`ifdef MCASH_FIXED_PRIO_EN
    always_comb begin
        pick = 3'b000;
        if (cand[0])      pick = 3'b001;
        else if (cand[1]) pick = 3'b010;
        else if (cand[2]) pick = 3'b100;
    end
`else
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        pick = 3'b000;
        case (ptr_q)
            2'd0: begin
                if (cand[0])      pick = 3'b001;
                else if (cand[1]) pick = 3'b010;
                else if (cand[2]) pick = 3'b100;
            end
            2'd1: begin
                if (cand[1])      pick = 3'b010;
                else if (cand[2]) pick = 3'b100;
                else if (cand[0]) pick = 3'b001;
            end
            default: begin
                if (cand[2])      pick = 3'b100;
                else if (cand[0]) pick = 3'b001;
                else if (cand[1]) pick = 3'b010;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant[0])      ptr_d = 2'd1;
        else if (grant[1]) ptr_d = 2'd2;
        else if (grant[2]) ptr_d = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) ptr_q <= 2'd0;
        else        ptr_q <= ptr_d;
    end
`endif

    logic [2:0]   sel_op;
    logic [27:0]  sel_addr;
    logic [127:0] sel_data;

    always_comb begin
        sel_op   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int c = 0; c < 3; c++) begin
            if (grant[c]) begin
                sel_op   = req_op[c];
                sel_addr = req_addr[c];
                sel_data = req_data[c];
            end
        end
    end

    logic [127:0]     mem_q   [LINES];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [LINES-1:0] valid_q;

    logic [IDX_W-1:0] sel_idx;
    logic [TAG_W-1:0] sel_tag;
    logic             hit;
    logic [127:0]     rd_line;
    logic             do_store;
    logic             do_return;

    assign sel_idx   = sel_addr[IDX_W-1:0];
    assign sel_tag   = sel_addr[27:IDX_W];
    assign hit       = valid_q[sel_idx] && (tag_q[sel_idx] == sel_tag);
    assign rd_line   = hit ? mem_q[sel_idx] : 128'h0;
    assign do_store  = (|grant) && (sel_op == OP_WRITE || sel_op == OP_SWAP);
    assign do_return = (sel_op == OP_READ || sel_op == OP_SWAP);

    // Line data and tags need no reset; the valid bits alone decide a hit.
    always_ff @(posedge clk_i) begin
        if (do_store) begin
            mem_q[sel_idx] <= sel_data;
            tag_q[sel_idx] <= sel_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
        end else if (do_store) begin
            valid_q[sel_idx] <= 1'b1;
        end else if ((|grant) && sel_op == OP_INV && hit) begin
            valid_q[sel_idx] <= 1'b0;
        end
    end

    // A new return overrides the pop of the old one in the same cycle.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (!rst_i) begin
                rtn_valid_q[c] <= 1'b0;
                rtn_data_q[c]  <= '0;
            end else if (grant[c] && do_return) begin
                rtn_valid_q[c] <= 1'b1;
                rtn_data_q[c]  <= rd_line;
            end else if (rtn_valid_q[c] && rtn_ready[c]) begin
                rtn_valid_q[c] <= 1'b0;
            end
        end
    end

    assign mcash_ch0_req_allowIn_o = grant[0];
    assign mcash_ch1_req_allowIn_o = grant[1];
    assign mcash_ch2_req_allowIn_o = grant[2];
    assign mcash_ch0_rtn_valid_o   = rtn_valid_q[0];
    assign mcash_ch1_rtn_valid_o   = rtn_valid_q[1];
    assign mcash_ch2_rtn_valid_o   = rtn_valid_q[2];
    assign mcash_ch0_rtn_data_o    = rtn_data_q[0];
    assign mcash_ch1_rtn_data_o    = rtn_data_q[1];
    assign mcash_ch2_rtn_data_o    = rtn_data_q[2];
endmodule

// File: tb/tb_mcash_cache.sv
// Directed self-checking bench for mcash_cache: miss/hit, write-then-read, arbitration, backpressure, swap/inv, reset.
module tb_mcash_cache;
    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] RD  = 3'b001;
    localparam logic [2:0] WR  = 3'b010;
    localparam logic [2:0] SW  = 3'b011;
    localparam logic [2:0] INV = 3'b100;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid [3];
    logic         allow_in  [3];
    logic [2:0]   req_op    [3];
    logic [27:0]  req_addr  [3];
    logic [127:0] req_data  [3];
    logic         rtn_valid [3];
    logic         rtn_ready [3];
    logic [127:0] rtn_data  [3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    mcash_cache #(.IDX_W(4)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .mcash_ch0_req_valid_i  (req_valid[0]),
        .mcash_ch0_req_allowIn_o(allow_in[0]),
        .mcash_ch0_req_op_i     (req_op[0]),
        .mcash_ch0_req_addr_i   (req_addr[0]),
        .mcash_ch0_req_data_i   (req_data[0]),
        .mcash_ch0_rtn_valid_o  (rtn_valid[0]),
        .mcash_ch0_rtn_ready_i  (rtn_ready[0]),
        .mcash_ch0_rtn_data_o   (rtn_data[0]),
        .mcash_ch1_req_valid_i  (req_valid[1]),
        .mcash_ch1_req_allowIn_o(allow_in[1]),
        .mcash_ch1_req_op_i     (req_op[1]),
        .mcash_ch1_req_addr_i   (req_addr[1]),
        .mcash_ch1_req_data_i   (req_data[1]),
        .mcash_ch1_rtn_valid_o  (rtn_valid[1]),
        .mcash_ch1_rtn_ready_i  (rtn_ready[1]),
        .mcash_ch1_rtn_data_o   (rtn_data[1]),
        .mcash_ch2_req_valid_i  (req_valid[2]),
        .mcash_ch2_req_allowIn_o(allow_in[2]),
        .mcash_ch2_req_op_i     (req_op[2]),
        .mcash_ch2_req_addr_i   (req_addr[2]),
        .mcash_ch2_req_data_i   (req_data[2]),
        .mcash_ch2_rtn_valid_o  (rtn_valid[2]),
        .mcash_ch2_rtn_ready_i  (rtn_ready[2]),
        .mcash_ch2_rtn_data_o   (rtn_data[2])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic v, input logic [2:0] op,
                         input logic [27:0] a, input logic [127:0] d);
        req_valid[ch] = v;
        req_op[ch]    = op;
        req_addr[ch]  = a;
        req_data[ch]  = d;
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [2:0]   exp_grant [6];
    logic [2:0]   grant_vec;
    logic [127:0] line_a5;
    logic [127:0] line_d7;

    initial begin
        line_a5 = {16{8'hA5}};
        line_d7 = {4{32'hDEAD_BEEF}};
`ifdef MCASH_FIXED_PRIO_EN
        exp_grant = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(c, 1'b0, NOP, 28'h0, 128'h0);
            rtn_ready[c] = 1'b1;
        end

        // Reset: allowIn held low even with a request pending
        drive(0, 1'b1, RD, 28'h2, 128'h0);
        tick();
        tick();
        chk("reset_allowin0", 128'(allow_in[0]), 128'h0);
        chk("reset_rtn_valid0", 128'(rtn_valid[0]), 128'h0);
        chk("reset_rtn_data0", rtn_data[0], 128'h0);
        rst_i = 1'b1;
        #1;
        chk("miss_allowin0", 128'(allow_in[0]), 128'h1);
        tick();
        chk("miss_rtn_valid0", 128'(rtn_valid[0]), 128'h1);
        chk("miss_rtn_data0", rtn_data[0], 128'h0);

        // Write then immediate read of the same line, then a conflicting tag
        drive(0, 1'b1, WR, 28'h2, line_a5);
        #1;
        chk("wr_allowin0", 128'(allow_in[0]), 128'h1);
        tick();
        chk("wr_no_return0", 128'(rtn_valid[0]), 128'h0);
        drive(0, 1'b1, RD, 28'h2, 128'h0);
        tick();
        chk("hit_rtn_valid0", 128'(rtn_valid[0]), 128'h1);
        chk("hit_rtn_data0", rtn_data[0], line_a5);
        drive(0, 1'b1, RD, 28'h12, 128'h0);
        tick();
        chk("tagmiss_rtn_data0", rtn_data[0], 128'h0);
        drive(0, 1'b0, NOP, 28'h0, 128'h0);
        tick();

        // Arbitration from a fresh pointer
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) drive(c, 1'b1, RD, 28'h2, 128'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            grant_vec = {allow_in[2], allow_in[1], allow_in[0]};
            chk($sformatf("arb_grant_%0d", i), 128'(grant_vec), 128'(exp_grant[i]));
            tick();
        end
        for (int c = 0; c < 3; c++) drive(c, 1'b0, NOP, 28'h0, 128'h0);
        tick();

        // Backpressure on ch1
        drive(1, 1'b1, WR, 28'h7, line_d7);
        #1;
        chk("bp_wr_allowin1", 128'(allow_in[1]), 128'h1);
        tick();
        drive(1, 1'b1, RD, 28'h7, 128'h0);
        rtn_ready[1] = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_allowin1_low_%0d", i), 128'(allow_in[1]), 128'h0);
            chk($sformatf("bp_rtn_valid1_%0d", i), 128'(rtn_valid[1]), 128'h1);
            chk($sformatf("bp_rtn_data1_%0d", i), rtn_data[1], line_d7);
            tick();
        end
        rtn_ready[1] = 1'b1;
        #1;
        chk("bp_allowin1_ready", 128'(allow_in[1]), 128'h1);
        tick();
        chk("bp_b2b_rtn_valid1", 128'(rtn_valid[1]), 128'h1);
        chk("bp_b2b_rtn_data1", rtn_data[1], line_d7);
        drive(1, 1'b0, NOP, 28'h0, 128'h0);
        tick();

        // Swap and invalidate on ch2
        drive(2, 1'b1, WR, 28'h5, 128'h1111);
        tick();
        drive(2, 1'b1, SW, 28'h5, 128'h2222);
        tick();
        chk("swap_rtn_valid2", 128'(rtn_valid[2]), 128'h1);
        chk("swap_old_data2", rtn_data[2], 128'h1111);
        drive(2, 1'b1, RD, 28'h5, 128'h0);
        tick();
        chk("swap_new_data2", rtn_data[2], 128'h2222);
        drive(2, 1'b1, INV, 28'h5, 128'h0);
        tick();
        chk("inv_no_return2", 128'(rtn_valid[2]), 128'h0);
        drive(2, 1'b1, RD, 28'h5, 128'h0);
        tick();
        chk("inv_rtn_valid2", 128'(rtn_valid[2]), 128'h1);
        chk("inv_rtn_data2", rtn_data[2], 128'h0);
        drive(2, 1'b0, NOP, 28'h0, 128'h0);
        tick();

        // Reset while a return is pending discards it and the stored line
        drive(0, 1'b1, WR, 28'h9, 128'h33);
        tick();
        drive(0, 1'b1, RD, 28'h9, 128'h0);
        rtn_ready[0] = 1'b0;
        tick();
        chk("pend_rtn_data0", rtn_data[0], 128'h33);
        drive(0, 1'b0, NOP, 28'h0, 128'h0);
        drive(2, 1'b1, RD, 28'h9, 128'h0);
        rst_i = 1'b0;
        #1;
        chk("rst_allowin2", 128'(allow_in[2]), 128'h0);
        tick();
        chk("rst_rtn_valid0", 128'(rtn_valid[0]), 128'h0);
        chk("rst_rtn_data0", rtn_data[0], 128'h0);
        drive(2, 1'b0, NOP, 28'h0, 128'h0);
        rst_i = 1'b1;
        rtn_ready[0] = 1'b1;
        drive(0, 1'b1, RD, 28'h9, 128'h0);
        tick();
        chk("post_rst_rtn_valid0", 128'(rtn_valid[0]), 128'h1);
        chk("post_rst_rtn_data0", rtn_data[0], 128'h0);
        drive(0, 1'b0, NOP, 28'h0, 128'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
